// File: rtl/daq_pkg.sv
// Shared types and default sizes for the DAQ circular-buffer controller.
package daq_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int DROP_CNT_W = 16;

    // Which side owns the single RAM port this cycle.
    typedef enum logic [1:0] {
        G_IDLE,
        G_WRITE,
        G_READ
    } grant_e;

    // Side that wins the next contested cycle.
    typedef enum logic {
        P_WRITE,
        P_READ
    } prio_e;

endpackage

// File: rtl/daq_arbiter.sv
// Single-port arbiter: grants the RAM port to the writer or the reader.
// Contested cycles alternate strictly between the two sides.
module daq_arbiter
    import daq_pkg::*;
(
    input  logic   want_w,
    input  logic   want_r,
    input  prio_e  prio,
    output grant_e grant,
    output prio_e  prio_next
);

    // Grant decision and priority hand-off for the next contested cycle.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        grant     = G_IDLE;
        prio_next = prio;
        if (want_w && want_r) begin
            if (prio == P_WRITE) begin
                grant     = G_WRITE;
                prio_next = P_READ;
            end else begin
                grant     = G_READ;
                prio_next = P_WRITE;
            end
        end else if (want_w) begin
            grant = G_WRITE;
        end else if (want_r) begin
            grant = G_READ;
        end
    end

endmodule

// File: rtl/daq_buffer_ctrl.sv
// Circular-buffer controller for the single-port DAQ_RAM.
// Writer and reader share one RAM access per clock through daq_arbiter.
// Optional feature macro: DAQ_DROP_EN (no upstream backpressure; bytes that
// cannot be stored are dropped and reported through overflow/drop_cnt).
module daq_buffer_ctrl
    import daq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [ADDR_W:0]       count,
    output logic                  empty,
    output logic                  full,
`ifdef DAQ_DROP_EN
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_we,
    output logic                  ram_ce,
    input  logic [DATA_W-1:0]     ram_q
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    prio_e             prio_q;
    prio_e             prio_next;
    grant_e            grant;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] last_addr;
    logic              want_w;
    logic              want_r;
    logic              do_write;
    logic              do_read;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Requests are masked during reset so nothing is granted then.
`ifdef DAQ_DROP_EN
    logic lost;
    assign want_w   = in_valid && !Reset;
    assign do_write = (grant == G_WRITE) && !full;
    assign in_ready = !Reset;
    // Any presented byte that does not land in the RAM is lost.
    assign lost     = in_valid && !Reset && !do_write;
`else
    assign want_w   = in_valid && !full && !Reset;
    assign do_write = (grant == G_WRITE);
    assign in_ready = (grant == G_WRITE);
`endif
    assign want_r  = rd_req && !empty && !Reset;
    assign do_read = (grant == G_READ);
    assign rd_ack  = do_read;

    daq_arbiter u_arbiter (
        .want_w    (want_w),
        .want_r    (want_r),
        .prio      (prio_q),
        .grant     (grant),
        .prio_next (prio_next)
    );

    // RAM pin drive; the address holds its last value while idle.
    always_comb begin
        ram_addr  = last_addr;
        ram_wdata = in_data;
        ram_we    = 1'b0;
        ram_ce    = 1'b0;
        if (do_write) begin
            ram_addr = wr_ptr;
            ram_we   = 1'b1;
            ram_ce   = 1'b1;
        end else if (do_read) begin
            ram_addr = rd_ptr;
            ram_ce   = 1'b1;
        end
    end

    // The RAM output is unregistered: data for a read shows up on ram_q the
    // cycle after the access, which is exactly the rd_valid cycle.
    assign rd_valid = rd_valid_q && !Reset;
    assign rd_data  = rd_valid ? ram_q : rd_data_q;

    // Pointers, fill count, priority and read-return state.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            prio_q     <= P_WRITE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            last_addr  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_read)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_write, do_read})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            prio_q     <= prio_next;
            rd_valid_q <= do_read;
            if (rd_valid) rd_data_q <= ram_q;
            if (ram_ce)   last_addr <= ram_addr;
        end
    end

`ifdef DAQ_DROP_EN
    // Sticky overflow flag and saturating lost-byte counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (lost)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (lost && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_daq_buffer_ctrl.sv
// Self-checking bench for daq_buffer_ctrl: a queue-based FIFO model plus a
// behavioural DAQ_RAM (registered read, NOREG output) drive every comparison.
module tb_daq_buffer_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [10:0] count;
    logic        empty;
    logic        full;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_ce;
    logic [7:0]  ram_q = '0;
`ifdef DAQ_DROP_EN
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    byte unsigned mq[$];
    bit   m_prio;      // 0: writer wins next contest
    int   m_wa, m_ra;  // expected RAM addresses
    bit   m_rv;        // read data expected this cycle
    byte unsigned m_rd;
    bit   m_ovf;
    int   m_drop;

    // Values observed at the last step's sample point.
    logic       obs_in_ready, obs_rd_ack;
    logic [9:0] obs_addr;

    logic [7:0] mem [1024];

    daq_buffer_ctrl dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .empty    (empty),
        .full     (full),
`ifdef DAQ_DROP_EN
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt),
`endif
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_ce   (ram_ce),
        .ram_q    (ram_q)
    );

    always #5 Clock = ~Clock;

    // Behavioural DAQ_RAM: synchronous write, read data appears after the edge.
    always @(posedge Clock) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_q <= mem[ram_addr];
        end
    end

    task automatic model_reset();
        mq.delete();
        m_prio = 0; m_wa = 0; m_ra = 0; m_rv = 0; m_rd = 0;
        m_ovf = 0; m_drop = 0;
    endtask

    // One clock of stimulus; the model predicts and checks every output.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int  g, sz;
        bit  ww, wr, land, lost, exp_ir;
        in_valid = v; in_data = d; rd_req = r;
        sz = mq.size();
`ifdef DAQ_DROP_EN
        ww = v;
`else
        ww = v && (sz < 1024);
`endif
        wr = r && (sz > 0);
        if (ww && wr) begin g = m_prio ? 2 : 1; m_prio = !m_prio; end
        else if (ww) g = 1;
        else if (wr) g = 2;
        else g = 0;
        land = (g == 1) && (sz < 1024);
        lost = v && !land;
`ifdef DAQ_DROP_EN
        exp_ir = 1'b1;
`else
        exp_ir = (g == 1);
`endif
        @(negedge Clock);
        obs_in_ready = in_ready; obs_rd_ack = rd_ack; obs_addr = ram_addr;
        n_checks += 7;
        if (in_ready !== exp_ir) begin n_fail++; $display("FAIL in_ready: got %b expected %b", in_ready, exp_ir); end
        if (rd_ack !== (g == 2)) begin n_fail++; $display("FAIL rd_ack: got %b expected %b", rd_ack, g == 2); end
        if (count !== 11'(sz)) begin n_fail++; $display("FAIL count: got %0d expected %0d", count, sz); end
        if (empty !== (sz == 0)) begin n_fail++; $display("FAIL empty: got %b expected %b", empty, sz == 0); end
        if (full !== (sz == 1024)) begin n_fail++; $display("FAIL full: got %b expected %b", full, sz == 1024); end
        if (ram_we !== land) begin n_fail++; $display("FAIL ram_we: got %b expected %b", ram_we, land); end
        if (ram_ce !== (land || g == 2)) begin n_fail++; $display("FAIL ram_ce: got %b expected %b", ram_ce, land || g == 2); end
        n_checks++;
        if (rd_valid !== m_rv) begin n_fail++; $display("FAIL rd_valid: got %b expected %b", rd_valid, m_rv); end
        if (m_rv) begin
            n_checks++;
            if (rd_data !== m_rd) begin n_fail++; $display("FAIL rd_data: got %02h expected %02h", rd_data, m_rd); end
        end
        if (land) begin
            n_checks += 2;
            if (ram_addr !== 10'(m_wa)) begin n_fail++; $display("FAIL wr_addr: got %0d expected %0d", ram_addr, m_wa); end
            if (ram_wdata !== d) begin n_fail++; $display("FAIL ram_wdata: got %02h expected %02h", ram_wdata, d); end
        end
        if (g == 2) begin
            n_checks++;
            if (ram_addr !== 10'(m_ra)) begin n_fail++; $display("FAIL rd_addr: got %0d expected %0d", ram_addr, m_ra); end
        end
`ifdef DAQ_DROP_EN
        n_checks += 2;
        if (overflow !== m_ovf) begin n_fail++; $display("FAIL overflow: got %b expected %b", overflow, m_ovf); end
        if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop); end
        if (lost) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
        if (lost && m_drop < 65535) m_drop++;
`endif
        if (land) begin mq.push_back(d); m_wa = (m_wa + 1) % 1024; end
        if (g == 2) begin m_rd = mq.pop_front(); m_rv = 1; m_ra = (m_ra + 1) % 1024; end
        else m_rv = 0;
        @(posedge Clock); #1;
    endtask

    task automatic apply_reset(input int n);
        Reset = 1; in_valid = 1; rd_req = 1; in_data = 8'h5A;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            n_checks++;
            if ({in_ready, rd_ack, rd_valid, ram_we, ram_ce} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected 00000", {in_ready, rd_ack, rd_valid, ram_we, ram_ce});
            end
            @(posedge Clock); #1;
        end
        Reset = 0; in_valid = 0; rd_req = 0;
        model_reset();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((mq.size() > 0 || m_rv) && guard < 2100) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        n_checks++;
        if (mq.size() != 0 || m_rv) begin n_fail++; $display("FAIL drain_budget: got %0d left expected 0", mq.size()); end
    endtask

    task automatic test_reset();
        apply_reset(3);
        @(negedge Clock);
        n_checks += 4;
        if (count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 10", empty, full); end
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %02h expected 00", rd_data); end
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        @(posedge Clock); #1;
    endtask

    task automatic test_basic();
        apply_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
        n_checks++;
        if (count !== 11'd10) begin n_fail++; $display("FAIL basic_count10: got %0d expected 10", count); end
        drain();
        n_checks++;
        if (count !== 11'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %0d/%b expected 0/1", count, empty); end
    endtask

    task automatic test_full();
        apply_reset(1);
        fill(1024);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hEF, 1'b0);
        n_checks += 2;
        if (full !== 1'b1 || count !== 11'd1024) begin n_fail++; $display("FAIL full_flag: got %b/%0d expected 1/1024", full, count); end
        if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_backpressure: got %b expected 0", obs_in_ready); end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hC3, 1'b0);
        n_checks++;
        if (obs_in_ready !== 1'b1 || obs_addr !== 10'd0) begin
            n_fail++; $display("FAIL full_refill_addr: got %b/%0d expected 1/0", obs_in_ready, obs_addr);
        end
        drain();
    endtask

    task automatic test_wrap();
        apply_reset(1);
        fill(1020);
        for (int i = 0; i < 1020; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        step(1'b1, 8'h77, 1'b0);
        n_checks++;
        if (obs_addr !== 10'd6) begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d expected 6", obs_addr); end
        drain();
    endtask

    task automatic test_alternate();
        apply_reset(1);
        fill(5);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            n_checks += 2;
            if (obs_in_ready !== ((i % 2) == 0) || obs_rd_ack !== ((i % 2) == 1)) begin
                n_fail++; $display("FAIL alternate_grant%0d: got w%b r%b expected w%b", i, obs_in_ready, obs_rd_ack, (i % 2) == 0);
            end
            if (count !== 11'd5 && count !== 11'd6) begin n_fail++; $display("FAIL alternate_count: got %0d expected 5 or 6", count); end
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        apply_reset(1);
        fill(3);
        step(1'b0, 8'h00, 1'b1);
        apply_reset(1);
        step(1'b1, 8'hA5, 1'b0);
        n_checks++;
        if (obs_addr !== 10'd0) begin n_fail++; $display("FAIL inflight_addr: got %0d expected 0", obs_addr); end
        drain();
    endtask

    task automatic test_random();
        apply_reset(1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
        drain();
    endtask

`ifdef DAQ_DROP_EN
    task automatic test_drop();
        apply_reset(1);
        fill(1024);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hDD, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd3) begin n_fail++; $display("FAIL drop_stats: got %b/%0d expected 1/3", overflow, drop_cnt); end
        ovf_clr = 1;
        step(1'b0, 8'h00, 1'b0);
        ovf_clr = 0;
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b expected 0", overflow); end
        drain();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_alternate();
        test_reset_inflight();
        test_random();
`ifdef DAQ_DROP_EN
        test_drop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/daq_buffer_ctrl.md
Name: daq_buffer_ctrl

Overview:
Circular-buffer controller for the 1024x8 single-port DAQ_RAM. It accepts a byte stream from the upstream message assembler, writes it into the RAM, and serves sequential byte reads to the downstream host interface. Both sides share the single RAM port, one access per clock, so the block arbitrates between them. It owns the write/read pointers, the fill count and the RAM control pins.

Parameters:
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W
DATA_W, 8, byte width of stream and RAM

Ports:
Clock  in  1  system clock, also drives DAQ_RAM Clock
Reset  in  1  synchronous, active-high reset
in_data  in  DATA_W  upstream byte
in_valid  in  1  upstream byte present
in_ready  out  1  byte accepted this cycle when in_valid&in_ready
rd_req  in  1  level; downstream wants one byte; held until rd_ack
rd_ack  out  1  one-cycle pulse: read issued to RAM this cycle
rd_data  out  DATA_W  byte read, valid with rd_valid
rd_valid  out  1  one-cycle pulse, exactly 1 cycle after rd_ack
count  out  ADDR_W+1  bytes stored, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
ram_addr  out  ADDR_W  to DAQ_RAM Address
ram_wdata  out  DATA_W  to DAQ_RAM Data
ram_we  out  1  to DAQ_RAM WE
ram_ce  out  1  to DAQ_RAM ClockEn
ram_q  in  DATA_W  from DAQ_RAM Q

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, count=0, prio=WRITE, rd_valid=0, rd_data=0; in_ready=0 and rd_ack=0 while Reset high; ram_we=0, ram_ce=0. Reset mid-operation discards all contents and any in-flight read (rd_valid not asserted the cycle after reset).
- Per cycle, exactly one of IDLE, WRITE, READ (combinational grant):
  - want_w = in_valid & !full; want_r = rd_req & !empty.
  - Only want_w -> WRITE. Only want_r -> READ. Both -> prio decides; prio toggles after every contested grant (strict alternation). Neither -> IDLE.
- in_ready = grant==WRITE; rd_ack = grant==READ.
- WRITE: ram_addr=wr_ptr, ram_wdata=in_data, ram_we=1, ram_ce=1; wr_ptr+1 mod DEPTH; count+1.
- READ: ram_addr=rd_ptr, ram_we=0, ram_ce=1; rd_ptr+1 mod DEPTH; count-1. Next cycle: rd_data<=ram_q captured combinationally from RAM (NOREG, 1-cycle latency), rd_valid=1.
- IDLE: ram_ce=0, ram_we=0; ram_addr holds last value.
- count changes by at most ±1 per cycle; never exceeds DEPTH, never below 0.
- Full: in_ready=0, bytes held upstream. Empty: rd_req not acked, held until a write lands; earliest ack is the cycle after the write.
- Pointers wrap 1023->0 silently; FIFO order preserved across wrap.
- rd_req dropped before ack: no read, no state change.

Optional Feature:
DAQ_DROP_EN. Defined: upstream has no backpressure; in_ready = !Reset always; when full, accepted bytes are discarded (no RAM write, pointers unchanged), sticky output overflow=1, cleared by input ovf_clr (pulse) or Reset; contested write still loses to read per prio but is then dropped, and drop_cnt (16-bit, saturating) counts lost bytes. Undefined: ports overflow/ovf_clr/drop_cnt absent; backpressure as above.

Decomposition:
- Package daq_pkg: ADDR_W/DATA_W defaults, DEPTH, grant enum {G_IDLE,G_WRITE,G_READ}.
- One sub-module natural: daq_arbiter (want_w, want_r, prio -> grant, next prio). Pointer/count logic stays in top.

Test Plan:
- Write 0x00..0x09, then rd_req held -> 10 acks, rd_valid each 1 cycle after ack, rd_data 0x00..0x09 in order, count 10->0, empty=1.
- Write 1024 bytes -> full=1, count=1024, in_ready=0 with in_valid held; one read -> next write accepted at address 0.
- Pre-fill 1020, read 1020, write 10 -> wr_ptr wraps to 6; read back returns bytes in written order across 1023->0.
- in_valid and rd_req both held, count=5 -> grants alternate W,R,W,R (starting W after reset); count stays 5/6.
- Reset asserted the cycle after rd_ack -> no rd_valid, count=0, pointers 0, next write to address 0.
- DAQ_DROP_EN: fill to 1024, push 3 more -> overflow=1, drop_cnt=3, RAM contents unchanged; ovf_clr -> overflow=0.
